// File: rtl/mult_gen_0_pkg.sv
// -----------------------------------------------------------------------------
// mult_gen_0_pkg
//
// Purpose:
//   Shared constants for the signed fixed-point multiplier mult_gen_0.
//   Holds the default operand width and fractional-bit count, plus the
//   fixed-point representation of 1.0 at those defaults.
//
// Contents:
//   DEF_WIDTH : default operand / product width in bits
//   DEF_FRAC  : default number of fractional bits (Q5.10 at defaults)
//   ONE       : fixed-point 1.0 at the default format (1 << DEF_FRAC)
// -----------------------------------------------------------------------------
package mult_gen_0_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_FRAC  = 10;

   // 1.0 in the default fixed-point format (16'h0400 at Q5.10).
   localparam int ONE = 1 << DEF_FRAC;

endpackage : mult_gen_0_pkg

// File: rtl/mult_gen_0_fx_pipe_reg.sv
// -----------------------------------------------------------------------------
// fx_pipe_reg
//
// Purpose:
//   One parameterized pipeline register stage with asynchronous active-low
//   reset. Used by mult_gen_0 to build both the product register and the
//   result register chain.
//
// Parameters:
//   W        : data width in bits
//
// Ports:
//   i_clk    : rising-edge clock
//   i_rst_n  : asynchronous active-low reset; clears the stage to zero
//   i_d      : stage input
//   o_q      : registered stage output
// -----------------------------------------------------------------------------
module fx_pipe_reg #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_q <= '0;
      end else begin
         o_q <= i_d;
      end
   end

endmodule : fx_pipe_reg

// File: rtl/mult_gen_0.sv
// -----------------------------------------------------------------------------
// mult_gen_0
//
// Purpose:
//   Pipelined signed fixed-point multiplier. Forms the full-precision product
//   A*B, arithmetically shifts it right by FRAC bits (floor, no rounding), then
//   either wraps to WIDTH bits or clamps to the signed WIDTH-bit range.
//   The result leaves the block through LATENCY register stages; every
//   operand pair is accepted on every clock edge.
//
// Parameters:
//   WIDTH    : operand and product width in bits
//   FRAC     : fractional bits of the fixed-point format
//   LATENCY  : register stages from A/B to P, legal range 1..4
//   SATURATE : 0 = wrap on overflow, 1 = clamp on overflow
//
// Ports:
//   CLK      : rising-edge clock (no assumption about clock phase)
//   RST_N    : asynchronous active-low reset; clears every pipeline register
//   A        : signed fixed-point multiplicand
//   B        : signed fixed-point multiplier
//   P        : signed fixed-point product, straight from the last register
// -----------------------------------------------------------------------------
module mult_gen_0
   import mult_gen_0_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC     = DEF_FRAC,
   parameter int LATENCY  = 1,
   parameter int SATURATE = 0
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   output logic signed [WIDTH-1:0] P
);

   localparam int PW = 2 * WIDTH;

   // Signed WIDTH-bit limits expressed at full product width so they can be
   // compared directly against the shifted product.
   localparam logic signed [PW-1:0] MAX_P = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [PW-1:0] MIN_P = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   // Shift the full product down by FRAC (arithmetic shift = floor), then
   // either keep the low WIDTH bits or clamp into the signed range.
   function automatic logic signed [WIDTH-1:0] fx_scale(
      input logic signed [PW-1:0] prod
   );
      logic signed [PW-1:0] sh;
      sh = prod >>> FRAC;
      if (SATURATE != 0) begin
         if (sh > MAX_P) begin
            return MAX_P[WIDTH-1:0];
         end else if (sh < MIN_P) begin
            return MIN_P[WIDTH-1:0];
         end
      end
      return sh[WIDTH-1:0];
   endfunction

   // Operands are sign-extended explicitly so the multiply is exact at PW bits.
   logic signed [PW-1:0] w_prod_p0;

   assign w_prod_p0 = $signed({{WIDTH{A[WIDTH-1]}}, A}) *
                      $signed({{WIDTH{B[WIDTH-1]}}, B});

   generate
      if (LATENCY <= 1) begin : g_lat1
         logic signed [WIDTH-1:0] w_res_p0;

         assign w_res_p0 = fx_scale(w_prod_p0);

         // ---- stage 0 -> P: multiply and scale in one cycle
         fx_pipe_reg #(
            .W (WIDTH)
         ) u_res_reg (
            .i_clk   (CLK),
            .i_rst_n (RST_N),
            .i_d     (w_res_p0),
            .o_q     (P)
         );
      end else begin : g_latn
         logic signed [PW-1:0]    r_prod_p1;
         logic signed [WIDTH-1:0] w_chain [LATENCY];

         // ---- stage 0 -> 1: register the full-precision product
         fx_pipe_reg #(
            .W (PW)
         ) u_prod_reg (
            .i_clk   (CLK),
            .i_rst_n (RST_N),
            .i_d     (w_prod_p0),
            .o_q     (r_prod_p1)
         );

         assign w_chain[0] = fx_scale(r_prod_p1);

         // ---- stages 1 .. LATENCY: scaled result register chain
         for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_chain
            fx_pipe_reg #(
               .W (WIDTH)
            ) u_res_reg (
               .i_clk   (CLK),
               .i_rst_n (RST_N),
               .i_d     (w_chain[gi]),
               .o_q     (w_chain[gi+1])
            );
         end

         assign P = w_chain[LATENCY-1];
      end
   endgenerate

endmodule : mult_gen_0

// File: tb/tb_mult_gen_0.sv
// -----------------------------------------------------------------------------
// tb_mult_gen_0
//
// Directed bench for mult_gen_0. Three instances share the operand inputs:
//   u_l1w : LATENCY=1, wrap
//   u_l1s : LATENCY=1, saturate
//   u_l3w : LATENCY=3, wrap (streaming and mid-stream reset)
// -----------------------------------------------------------------------------
module tb_mult_gen_0;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] p_l1w;
   logic [15:0] p_l1s;
   logic [15:0] p_l3w;

   int checks   = 0;
   int failures = 0;

   // Hand-computed vectors (Q5.10): operands, wrapped result, saturated result.
   logic [15:0] va [12];
   logic [15:0] vb [12];
   logic [15:0] ew [12];
   logic [15:0] es [12];

   mult_gen_0 #(.WIDTH(16), .FRAC(10), .LATENCY(1), .SATURATE(0)) u_l1w (
      .CLK (CLK), .RST_N (RST_N), .A (A), .B (B), .P (p_l1w)
   );

   mult_gen_0 #(.WIDTH(16), .FRAC(10), .LATENCY(1), .SATURATE(1)) u_l1s (
      .CLK (CLK), .RST_N (RST_N), .A (A), .B (B), .P (p_l1s)
   );

   mult_gen_0 #(.WIDTH(16), .FRAC(10), .LATENCY(3), .SATURATE(0)) u_l3w (
      .CLK (CLK), .RST_N (RST_N), .A (A), .B (B), .P (p_l3w)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   task automatic step(input int i);
      A = va[i];
      B = vb[i];
      @(posedge CLK);
      #1;
   endtask

   initial begin
      va[0]  = 16'h0800; vb[0]  = 16'h0100; ew[0]  = 16'h0200; es[0]  = 16'h0200; // 2.0*0.25
      va[1]  = 16'hFC00; vb[1]  = 16'h0800; ew[1]  = 16'hF800; es[1]  = 16'hF800; // -1.0*2.0
      va[2]  = 16'h0001; vb[2]  = 16'h0001; ew[2]  = 16'h0000; es[2]  = 16'h0000; // floor +
      va[3]  = 16'h0001; vb[3]  = 16'hFFFF; ew[3]  = 16'hFFFF; es[3]  = 16'hFFFF; // floor -
      va[4]  = 16'h4000; vb[4]  = 16'h0800; ew[4]  = 16'h8000; es[4]  = 16'h7FFF; // 16*2 ovf
      va[5]  = 16'h8000; vb[5]  = 16'h8000; ew[5]  = 16'h0000; es[5]  = 16'h7FFF; // -32^2
      va[6]  = 16'h8000; vb[6]  = 16'h0400; ew[6]  = 16'h8000; es[6]  = 16'h8000; // -32*1 at min
      va[7]  = 16'h7FFF; vb[7]  = 16'h0400; ew[7]  = 16'h7FFF; es[7]  = 16'h7FFF; // max*1
      va[8]  = 16'h8000; vb[8]  = 16'h0800; ew[8]  = 16'h0000; es[8]  = 16'h8000; // -64 underflow
      va[9]  = 16'h0C00; vb[9]  = 16'hFA00; ew[9]  = 16'hEE00; es[9]  = 16'hEE00; // 3*-1.5
      va[10] = 16'h7FFF; vb[10] = 16'h7FFF; ew[10] = 16'hFFC0; es[10] = 16'h7FFF; // max^2
      va[11] = 16'h0000; vb[11] = 16'h1234; ew[11] = 16'h0000; es[11] = 16'h0000; // zero

      // Reset held across edges with live operands: all outputs stay zero.
      RST_N = 1'b0;
      A     = 16'h1234;
      B     = 16'h0400;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_l1w", p_l1w, 16'h0000);
      chk("rst_l1s", p_l1s, 16'h0000);
      chk("rst_l3w", p_l3w, 16'h0000);

      @(negedge CLK);
      RST_N = 1'b1;

      // Back-to-back stream; the LATENCY=3 output trails by two sampling steps.
      for (int k = 0; k < 12; k++) begin
         step(k);
         chk($sformatf("l1w_v%0d", k), p_l1w, ew[k]);
         chk($sformatf("l1s_v%0d", k), p_l1s, es[k]);
         if (k >= 2) chk($sformatf("l3w_v%0d", k), p_l3w, ew[k-2]);
         else        chk($sformatf("l3w_fill%0d", k), p_l3w, 16'h0000);
      end
      step(0);
      chk("l3w_drain0", p_l3w, ew[10]);
      step(0);
      chk("l3w_drain1", p_l3w, ew[11]);
      step(0);
      chk("l3w_full", p_l3w, ew[0]);

      // Asynchronous reset between edges with products in flight.
      #2;
      RST_N = 1'b0;
      #1;
      chk("arst_l1w", p_l1w, 16'h0000);
      chk("arst_l1s", p_l1s, 16'h0000);
      chk("arst_l3w", p_l3w, 16'h0000);
      @(posedge CLK);
      #1;
      chk("arst_hold_l1w", p_l1w, 16'h0000);
      chk("arst_hold_l3w", p_l3w, 16'h0000);
      @(negedge CLK);
      RST_N = 1'b1;

      // After release: LATENCY=3 reads zero for two edges, then new data only.
      step(1);
      chk("post_l1w_0", p_l1w, ew[1]);
      chk("post_l3w_0", p_l3w, 16'h0000);
      step(9);
      chk("post_l1w_1", p_l1w, ew[9]);
      chk("post_l3w_1", p_l3w, 16'h0000);
      step(7);
      chk("post_l1w_2", p_l1w, ew[7]);
      chk("post_l3w_2", p_l3w, ew[1]);
      step(0);
      chk("post_l3w_3", p_l3w, ew[9]);
      step(0);
      chk("post_l3w_4", p_l3w, ew[7]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish in time");
   end

endmodule : tb_mult_gen_0

// File: doc/mult_gen_0.md
MULT_GEN_0 -- requirements
Module: mult_gen_0

Interface
REQ-001 Parameter WIDTH, default 16: operand and product width in bits.
REQ-002 Parameter FRAC, default 10: fractional bits of the signed fixed-point format (Q5.10 at defaults, 1.0 = 16'h0400).
REQ-003 Parameter LATENCY, default 1, legal range 1..4: number of register stages from A/B to P.
REQ-004 Parameter SATURATE, default 0: 0 = wrap on overflow, 1 = clamp on overflow.
REQ-005 CLK  input  1  rising-edge clock; the block uses a single clock domain.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 A  input  WIDTH  signed fixed-point multiplicand.
REQ-008 B  input  WIDTH  signed fixed-point multiplier.
REQ-009 P  output  WIDTH  signed fixed-point product, driven directly from the final pipeline register.

Function
REQ-010 The block SHALL form the full signed product A*B at 2*WIDTH bits with no loss of precision.
REQ-011 It SHALL arithmetically shift the full product right by FRAC bits, truncating toward negative infinity (floor), with no rounding.
REQ-012 With SATURATE=0, P SHALL be the low WIDTH bits of the shifted product (two's-complement wrap).
REQ-013 With SATURATE=1, a shifted product above the maximum WIDTH-bit signed value SHALL give P = 16'h7FFF at defaults.
REQ-014 With SATURATE=1, a shifted product below the minimum WIDTH-bit signed value SHALL give P = 16'h8000 at defaults.
REQ-015 Operands sampled on rising edge N SHALL appear on P immediately after rising edge N+LATENCY-1; at LATENCY=1 they appear after the same edge.
REQ-016 The block SHALL accept a new operand pair on every clock edge, with full throughput and no stalls.
REQ-017 P SHALL change only on a rising CLK edge or on reset assertion; there is no combinational path from A/B to P.
REQ-018 Intermediate results SHALL advance one pipeline stage per clock edge.
REQ-019 Operand bits SHALL be treated as signed; A=B=16'h8000 (-32.0 squared) is an overflow case handled by REQ-012..014.
REQ-020 The block SHALL work when its CLK is driven from an inverted system clock; it SHALL contain no assumption about clock phase.

Reset
REQ-021 While RST_N=0, P and all pipeline registers SHALL be 0, asynchronously and regardless of CLK.
REQ-022 After RST_N deasserts, the first valid P SHALL appear LATENCY edges later; P SHALL read 0 until then.
REQ-023 Reset asserted mid-pipeline SHALL discard all in-flight products, and no stale product SHALL ever appear after reset.

Structure
REQ-024 A shared package SHALL hold the default WIDTH/FRAC constants and a fixed-point helper constant ONE = 1 << FRAC.
REQ-025 Saturation bounds SHALL be derived from WIDTH inside the module, not hard-coded.
REQ-026 The block SHALL be a single flat module: a multiply stage, a shift/wrap-or-saturate stage, and a LATENCY-deep register chain.
REQ-027 One sub-module, fx_pipe_reg (a parameterized register stage with asynchronous active-low reset), is permitted and natural.

Verification
REQ-028 Basic fractional product: A=16'h0800 (2.0), B=16'h0100 (0.25), LATENCY=1 -> P=16'h0200 (0.5) after one edge.
REQ-029 Negative operand: A=16'hFC00 (-1.0), B=16'h0800 (2.0) -> P=16'hF800 (-2.0).
REQ-030 Floor truncation: A=16'h0001, B=16'h0001 -> P=16'h0000.
REQ-031 Floor truncation, negative: A=16'h0001, B=16'hFFFF -> P=16'hFFFF.
REQ-032 Overflow: A=16'h4000 (16.0), B=16'h0800 (2.0) -> P=16'h8000 with SATURATE=0, P=16'h7FFF with SATURATE=1.
REQ-033 Streaming: LATENCY=3 with a new operand pair every edge -> each P matches the pair applied 3 edges earlier, back-to-back with no gaps.
REQ-034 Reset mid-stream: pulse RST_N low while products are in flight -> P=0 immediately, remains 0 until LATENCY edges after release, and then tracks new inputs only.
